// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes,
// FSM state encoding, op select values and the ALU request payload.
package mdu_pkg;

    localparam int unsigned MDU_W = 32;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Operands and op code presented to the shared ALU.
    typedef struct packed {
        logic [MDU_W-1:0] a;
        logic [MDU_W-1:0] b;
        logic [3:0]       aluc;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Existing 32-bit combinational ALU shared with the CPU datapath.
// Ports:
//   a, b  : operands
//   aluc  : op code (x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR,
//           x110 LUI, 0011 SLL, 0111 SRL, 1111 SRA)
//   r     : combinational result
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r
);

    // Result select on the low two op bits, variant on bit 2 (and bit 3 for shifts).
    always_comb begin
        r = 32'h0;
        unique case (aluc[1:0])
            2'b00: r = aluc[2] ? (a - b) : (a + b);
            2'b01: r = aluc[2] ? (a | b) : (a & b);
            2'b10: r = aluc[2] ? {b[15:0], 16'h0} : (a ^ b);
            2'b11: begin
                if (!aluc[2])
                    r = b << a[4:0];
                else if (!aluc[3])
                    r = b >> a[4:0];
                else
                    r = 32'($signed(b) >>> a[4:0]);
            end
            default: r = 32'h0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply / divide sequencer that time-shares the
// CPU's combinational ALU, one radix-2 iteration per clock.
// Ports:
//   clk, clrn        : clock, asynchronous active-low reset
//   start, op, x, y  : request (op 0 = MUL, 1 = DIV), sampled in IDLE only
//   busy, done       : decoded from state; done pulses for one cycle
//   hi, lo           : MUL product {hi,lo}; DIV remainder (hi) / quotient (lo)
//   alu_a/b/aluc     : operands driven to the shared ALU
//   alu_r            : ALU result
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_W,
    parameter int unsigned ITER  = MDU_W
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_r
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mdu_state_e       state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] rs;
    logic             carry;
    logic             ge;
    alu_req_t         alu_req;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Next state; busy/done decode straight from the registered state.
    always_comb begin
        state_d = state;
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL)
                        state_d = ST_MUL;
                    else if (y == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt == CNT_LAST)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU operand steering; idle ALU sees ADD of zeros.
    always_comb begin
        alu_req      = '0;
        alu_req.aluc = ALUC_ADD;
        rs           = {hi[WIDTH-2:0], lo[WIDTH-1]};
        unique case (state)
            ST_MUL: begin
                alu_req.a = hi;
                alu_req.b = lo[0] ? opnd : '0;
            end
            ST_DIV: begin
                alu_req.a    = rs;
                alu_req.b    = opnd;
                alu_req.aluc = ALUC_SUB;
            end
            default: ;
        endcase
    end

    assign alu_a    = alu_req.a;
    assign alu_b    = alu_req.b;
    assign alu_aluc = alu_req.aluc;

    // Carry out of the wrapped add, and "partial remainder fits" for divide.
    // hi[MSB] set means the shifted remainder exceeds 32 bits, so it always fits.
    assign carry = (alu_r < alu_req.a);
    assign ge    = hi[WIDTH-1] | (rs >= opnd);

    // Datapath: operand latch, shift-add multiply, restoring divide, counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            opnd <= x;
                            hi   <= '0;
                            lo   <= y;
                            cnt  <= '0;
                        end else if (y != '0) begin
                            opnd <= y;
                            hi   <= '0;
                            lo   <= x;
                            cnt  <= '0;
                        end else begin
                            hi <= x;
                            lo <= '1;
                        end
                    end
                end
                ST_MUL: begin
                    {hi, lo} <= {carry, alu_r, lo[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                ST_DIV: begin
                    hi  <= ge ? alu_r : rs;
                    lo  <= {lo[WIDTH-2:0], ge};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer that time-shares the existing 32-bit combinational ALU.
- Performs unsigned 32x32 multiply (64-bit product) and unsigned 32/32 divide, one radix-2 iteration per clock.
- Drives the ALU operands and aluc code, and receives the ALU result.
- Sits beside the CPU datapath. The CPU issues start, stalls on busy, and reads hi/lo when done pulses.

Parameters:
- WIDTH, 32, operand/ALU width (only 32 is supported).
- ITER, 32, iterations per operation (must equal WIDTH).

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only in IDLE
- op  in  1  0 = MUL (unsigned), 1 = DIV (unsigned); sampled with start
- x  in  32  multiplicand / dividend; sampled with start
- y  in  32  multiplier / divisor; sampled with start
- busy  out  1  high in MUL, DIV and DONE states
- done  out  1  one-cycle pulse; hi/lo valid from this cycle
- hi  out  32  MUL: product[63:32]; DIV: remainder
- lo  out  32  MUL: product[31:0]; DIV: quotient
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_aluc  out  4  ALU op code: ADD = 4'b0000, SUB = 4'b0100
- alu_r  in  32  ALU result (combinational from alu_a/alu_b/alu_aluc)

Behaviour:
- Reset (clrn = 0, asynchronous):
  - state = IDLE; busy = 0, done = 0, hi = 0, lo = 0, cnt = 0.
  - Internal operand register opnd = 0.
  - A reset mid-operation aborts the operation with no done pulse.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE, start = 1, op = 0:
    - opnd <= x, hi <= 0, lo <= y, cnt <= 0, go to MUL.
  - IDLE, start = 1, op = 1, y != 0:
    - opnd <= y, hi <= 0, lo <= x, cnt <= 0, go to DIV.
  - IDLE, start = 1, op = 1, y == 0 (divide by zero):
    - hi <= x, lo <= 32'hFFFF_FFFF, go to DONE.
  - MUL (one iteration per cycle):
    - alu_a = hi; alu_b = lo[0] ? opnd : 0; alu_aluc = ADD.
    - carry = (alu_r < alu_a), unsigned.
    - {hi, lo} <= {carry, alu_r, lo[31:1]}.
  - DIV (restoring, one iteration per cycle):
    - rs = {hi[30:0], lo[31]}.
    - alu_a = rs; alu_b = opnd; alu_aluc = SUB.
    - ge = hi[31] | (rs >= opnd), unsigned.
    - hi <= ge ? alu_r : rs; lo <= {lo[30:0], ge}.
  - MUL/DIV: cnt increments every cycle. When cnt == ITER-1, perform the last iteration and go to DONE.
  - DONE: done = 1 for exactly this cycle; go to IDLE next cycle.
- Outside MUL/DIV: alu_a = 0, alu_b = 0, alu_aluc = ADD.
- start in any state other than IDLE is ignored; no queuing.
- start in the same cycle as DONE is ignored. It is accepted on the following IDLE cycle.
- Latency:
  - start sampled at edge E0; busy = 1 from E0.
  - 32 iteration edges follow; done is high in the cycle after edge E32.
  - Total: 33 cycles from start to done.
  - Divide by zero: done is high in the cycle after E0.
- hi/lo hold their values in IDLE until the next accepted start.
- busy and done are decoded directly from registered state, with no combinational path from start.
- The ALU output is used as-is, wrapping modulo 2^32. Carry and borrow are derived locally as defined above.

Decomposition:
- Shared package mdu_pkg:
  - ALUC_ADD = 4'b0000, ALUC_SUB = 4'b0100.
  - State encoding: IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3.
  - OP_MUL = 1'b0, OP_DIV = 1'b1.
- No sub-module. FSM, counter and hi/lo/opnd registers live in one module.
- The bench instantiates mdu_seq together with the existing ALU, connecting alu_a/alu_b/alu_aluc to it and its r output to alu_r.

Test Plan:
- MUL 3 x 5 -> done in the cycle after E32; hi = 0, lo = 15; busy high for 33 cycles.
- MUL 32'hFFFFFFFF x 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001 (exercises carry every iteration).
- DIV 100 / 7 -> lo = 14, hi = 2. DIV 32'h80000000 / 3 -> lo = 32'h2AAAAAAA, hi = 2. DIV 32'hFFFFFFFF / 32'hFFFFFFFF -> lo = 1, hi = 0.
- DIV 1234 / 0 -> done in the cycle after E0; hi = 1234, lo = 32'hFFFFFFFF.
- start pulsed at iterations 5 and 31 and in the DONE cycle with different x/y -> ignored; result matches the first request. A start in the following IDLE cycle is accepted.
- clrn low at iteration 10 of a MUL -> immediately busy = 0, hi = lo = 0, no done pulse. A new MUL 7 x 6 after release -> lo = 42.
